// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   FWD_*        : forwarding mux select encodings for ForwardAE/ForwardBE
//   RESULT_LOAD  : ResultSrcE encoding that marks a load in execute
//   state_t      : data-memory wait FSM states
//   fwd_sel()    : forwarding select for one execute-stage source register
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;  // register file read data
   localparam logic [1:0] FWD_WB  = 2'b01;  // ResultW
   localparam logic [1:0] FWD_MEM = 2'b10;  // ALUResultM

   localparam logic [1:0] RESULT_LOAD = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } state_t;

   // x0 is hardwired to zero, so it is never forwarded. The younger
   // producer (M) wins over the older one (W).
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_m,
                                          input logic       we_m,
                                          input logic [4:0] rd_w,
                                          input logic       we_w);
      logic [1:0] sel;
      sel = FWD_RF;
      if (rs != 5'd0) begin
         if (rs == rd_m && we_m)
            sel = FWD_MEM;
         else if (rs == rd_w && we_w)
            sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
//   clk   : rising-edge clock
//   clr   : synchronous clear, dominates inc
//   inc   : count one event this cycle
//   count : current value, holds at all-ones
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr)
         count <= '0;
      else if (inc && count != '1)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard / stall / flush controller for a 5-stage pipeline.
// Drives the stall and clear inputs of every pipeline latch; FlushE is the
// clr of the decode->execute latch. RAW hazards are forwarded, load-use
// hazards get a one-cycle stall plus bubble, taken branches/jumps flush D and
// E, and the whole pipe freezes while data memory is not ready. A memory
// access that stays not-ready past MEM_TIMEOUT wait cycles sets the sticky
// mem_err flag and freezes the pipe until reset.
//
// Optional feature: define PIPE_PERF_CNT_EN to build the stall/flush
// performance counters; otherwise stall_cnt and flush_cnt are tied to 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   Rs1D, Rs2D               decode-stage source registers
//   Rs1E, Rs2E               execute-stage source registers
//   RdE, RdM, RdW            destination registers in E/M/W
//   ResultSrcE               2'b01 marks a load in execute
//   RegWriteM, RegWriteW     M/W stage write the register file
//   PCSrcE                   taken branch / jump / jalr resolved in execute
//   mem_req_M, mem_ready_M   data-memory request / completion in M
//   ForwardAE, ForwardBE     forwarding selects for the ALU operands
//   StallF..StallM           hold the corresponding latch
//   FlushD, FlushE, FlushW   clear the corresponding latch at the next edge
//   mem_err                  sticky memory timeout flag
//   stall_cnt, flush_cnt     performance counters
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic [1:0]       ResultSrcE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             PCSrcE,
   input  logic             mem_req_M,
   input  logic             mem_ready_M,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       mem_err_nxt;
   logic       lw_stall;
   logic       mem_stall;

   // ---------------- memory wait FSM ----------------
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         mem_err  <= mem_err_nxt;
      end
   end

   always_comb begin
      // NOTE: every variable gets a default before any branch; a path that
      // leaves one unassigned would infer a latch.
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      mem_err_nxt  = mem_err;
      unique case (state)
         IDLE: begin
            if (mem_req_M && !mem_ready_M) begin
               state_nxt    = WAIT;
               wait_cnt_nxt = 8'd1;
            end
         end
         WAIT: begin
            if (mem_ready_M) begin
               state_nxt    = IDLE;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == TIMEOUT_CNT) begin
               state_nxt   = ERR;
               mem_err_nxt = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         ERR:     ;  // terminal until reset
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- hazard detection ----------------
   assign lw_stall  = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                      ((Rs1D == RdE) || (Rs2D == RdE));

   assign mem_stall = ((state == WAIT || state == IDLE) && mem_req_M && !mem_ready_M) ||
                      (state == ERR);

   // A branch or load-use that coincides with a memory stall is simply held
   // in its latch by the freeze and gets acted on once the stall releases.
   always_comb begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      if (rst) begin
         // Clear the D/E/W latches while reset is held.
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushW = 1'b1;
      end else begin
         ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
         ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
         if (mem_stall) begin
            // Freeze F..M; the bubble into W keeps the stalled access from
            // retiring more than once.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (PCSrcE) begin
            // The flush discards the decode instruction, so StallD is moot,
            // but the fetch PC is still held while a load-use is pending.
            FlushD = 1'b1;
            FlushE = 1'b1;
            StallF = lw_stall;
         end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   // ---------------- performance counters ----------------
`ifdef PIPE_PERF_CNT_EN
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (StallF),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (FlushD | FlushE),
      .count (flush_cnt)
   );
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
   import hazard_pkg::*;

   localparam int CNT_W       = 32;
   localparam int MEM_TIMEOUT = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [4:0]       Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0;
   logic [4:0]       RdE = '0, RdM = '0, RdW = '0;
   logic [1:0]       ResultSrcE = '0;
   logic             RegWriteM = 1'b0, RegWriteW = 1'b0, PCSrcE = 1'b0;
   logic             mem_req_M = 1'b0, mem_ready_M = 1'b0;
   logic [1:0]       ForwardAE, ForwardBE;
   logic             StallF, StallD, StallE, StallM;
   logic             FlushD, FlushE, FlushW;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .Rs1D        (Rs1D),
      .Rs2D        (Rs2D),
      .Rs1E        (Rs1E),
      .Rs2E        (Rs2E),
      .RdE         (RdE),
      .RdM         (RdM),
      .RdW         (RdW),
      .ResultSrcE  (ResultSrcE),
      .RegWriteM   (RegWriteM),
      .RegWriteW   (RegWriteW),
      .PCSrcE      (PCSrcE),
      .mem_req_M   (mem_req_M),
      .mem_ready_M (mem_ready_M),
      .ForwardAE   (ForwardAE),
      .ForwardBE   (ForwardBE),
      .StallF      (StallF),
      .StallD      (StallD),
      .StallE      (StallE),
      .StallM      (StallM),
      .FlushD      (FlushD),
      .FlushE      (FlushE),
      .FlushW      (FlushW),
      .mem_err     (mem_err),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   // One cycle of stimulus plus the outputs it must produce.
   // stall = {F,D,E,M}, flush = {D,E,W}
   typedef struct {
      string      name;
      logic       rst;
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic [1:0] rsrc;
      logic       rwm, rww, pcsrc, req, rdy;
      logic [1:0] fa, fb;
      logic [3:0] stall;
      logic [2:0] flush;
   } vec_t;

   typedef struct {
      string      name;
      logic [1:0] fa, fb;
      logic [3:0] stall;
      logic [2:0] flush;
   } exp_t;

   exp_t sb_q[$];
   vec_t tbl[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t idle_vec(input string name);
      vec_t v;
      v.name = name;
      v.rst  = 1'b0;
      v.rs1d = '0; v.rs2d = '0; v.rs1e = '0; v.rs2e = '0;
      v.rde  = '0; v.rdm  = '0; v.rdw  = '0;
      v.rsrc = 2'b00;
      v.rwm  = 1'b0; v.rww = 1'b0; v.pcsrc = 1'b0; v.req = 1'b0; v.rdy = 1'b0;
      v.fa   = FWD_RF; v.fb = FWD_RF;
      v.stall = 4'b0000; v.flush = 3'b000;
      return v;
   endfunction

   // Drive one vector just after the rising edge, queue its expectation, and
   // compare on the falling edge of the same cycle.
   task automatic step(input vec_t v);
      exp_t e;
      @(posedge clk);
      #1;
      rst = v.rst;
      Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
      RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
      ResultSrcE = v.rsrc; RegWriteM = v.rwm; RegWriteW = v.rww;
      PCSrcE = v.pcsrc; mem_req_M = v.req; mem_ready_M = v.rdy;
      e.name = v.name; e.fa = v.fa; e.fb = v.fb; e.stall = v.stall; e.flush = v.flush;
      sb_q.push_back(e);
      @(negedge clk);
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", v.name);
      end else begin
         e = sb_q.pop_front();
         check({e.name, "/ForwardAE"}, 32'(ForwardAE), 32'(e.fa));
         check({e.name, "/ForwardBE"}, 32'(ForwardBE), 32'(e.fb));
         check({e.name, "/stall"}, 32'({StallF, StallD, StallE, StallM}), 32'(e.stall));
         check({e.name, "/flush"}, 32'({FlushD, FlushE, FlushW}), 32'(e.flush));
      end
   endtask

   initial begin
      vec_t v;
      vec_t rst_v;
      vec_t lw_v;
      vec_t pc_lw_v;
      logic [31:0] exp_stall_cnt;
      logic [31:0] exp_flush_cnt;

      // ---- combinational table, FSM stays in IDLE throughout ----
      v = idle_vec("fwd_a_mem"); v.rs1e = 5; v.rdm = 5; v.rwm = 1; v.rdw = 5; v.rww = 1;
      v.fa = FWD_MEM; tbl[0] = v;
      v.name = "fwd_a_wb"; v.rwm = 0; v.fa = FWD_WB; tbl[1] = v;
      v.name = "fwd_a_x0"; v.rs1e = 0; v.rdm = 0; v.rdw = 0; v.rwm = 1; v.fa = FWD_RF; tbl[2] = v;
      v = idle_vec("fwd_b_mem"); v.rs2e = 9; v.rdm = 9; v.rwm = 1; v.fb = FWD_MEM; tbl[3] = v;
      v = idle_vec("fwd_b_wb"); v.rs2e = 3; v.rdw = 3; v.rww = 1; v.rdm = 4; v.rwm = 1;
      v.fb = FWD_WB; tbl[4] = v;
      v = idle_vec("fwd_w_nowrite"); v.rs1e = 6; v.rdw = 6; v.rww = 0; tbl[5] = v;
      v = idle_vec("lw_rs1"); v.rsrc = RESULT_LOAD; v.rde = 7; v.rs1d = 7;
      v.stall = 4'b1100; v.flush = 3'b010; tbl[6] = v;
      v = idle_vec("lw_rd0"); v.rsrc = RESULT_LOAD; v.rde = 0; v.rs1d = 0; tbl[7] = v;
      v = idle_vec("not_load"); v.rsrc = 2'b10; v.rde = 7; v.rs2d = 7; tbl[8] = v;
      v = idle_vec("branch"); v.pcsrc = 1; v.flush = 3'b110; tbl[9] = v;
      v = idle_vec("branch_lw"); v.pcsrc = 1; v.rsrc = RESULT_LOAD; v.rde = 8; v.rs2d = 8;
      v.stall = 4'b1000; v.flush = 3'b110; tbl[10] = v;
      v = idle_vec("mem_ready_now"); v.req = 1; v.rdy = 1; tbl[11] = v;

      rst_v = idle_vec("reset"); rst_v.rst = 1; rst_v.rs1e = 5; rst_v.rdm = 5; rst_v.rwm = 1;
      rst_v.rsrc = RESULT_LOAD; rst_v.rde = 7; rst_v.rs1d = 7; rst_v.req = 1;
      rst_v.flush = 3'b111;

      // ---- reset state ----
      step(rst_v);
      step(idle_vec("after_reset"));
      check("reset/mem_err", 32'(mem_err), 32'd0);
      check("reset/stall_cnt", stall_cnt, 32'd0);
      check("reset/flush_cnt", flush_cnt, 32'd0);

      for (int i = 0; i < 12; i++) step(tbl[i]);

      // ---- load-use: one stall cycle, then forward from M ----
      step(rst_v);
      lw_v = idle_vec("lu_stall"); lw_v.rsrc = RESULT_LOAD; lw_v.rde = 7; lw_v.rs2d = 7;
      lw_v.stall = 4'b1100; lw_v.flush = 3'b010;
      step(lw_v);
      v = idle_vec("lu_forward"); v.rs2e = 7; v.rdm = 7; v.rwm = 1; v.fb = FWD_MEM;
      step(v);
      pc_lw_v = tbl[10]; pc_lw_v.name = "lu_branch";
      step(pc_lw_v);
      step(idle_vec("lu_idle"));
`ifdef PIPE_PERF_CNT_EN
      // StallF was high in the load-use cycle and again in the branch cycle,
      // because the pending load-use still holds fetch under a flush.
      exp_stall_cnt = 32'd2;
      exp_flush_cnt = 32'd2;
`else
      exp_stall_cnt = 32'd0;
      exp_flush_cnt = 32'd0;
`endif
      check("perf/stall_cnt", stall_cnt, exp_stall_cnt);
      check("perf/flush_cnt", flush_cnt, exp_flush_cnt);

      // ---- memory wait: 3 frozen cycles, branch acted on after release ----
      for (int i = 0; i < 3; i++) begin
         v = idle_vec($sformatf("mwait_%0d", i)); v.req = 1; v.rdy = 0; v.pcsrc = 1;
         v.stall = 4'b1111; v.flush = 3'b001;
         step(v);
      end
      v = idle_vec("mwait_release"); v.req = 1; v.rdy = 1; v.pcsrc = 1; v.flush = 3'b110;
      step(v);
      step(idle_vec("mwait_idle"));
      check("mwait/mem_err", 32'(mem_err), 32'd0);

      // ---- timeout: 1 IDLE cycle plus MEM_TIMEOUT WAIT cycles ----
      step(rst_v);
      for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
         v = idle_vec($sformatf("tmo_%0d", i)); v.req = 1; v.rdy = 0;
         v.stall = 4'b1111; v.flush = 3'b001;
         step(v);
      end
      check("tmo/mem_err_before", 32'(mem_err), 32'd0);
      v = idle_vec("err_frozen"); v.req = 0; v.rdy = 1; v.pcsrc = 1;
      v.stall = 4'b1111; v.flush = 3'b001;
      step(v);
      check("err/mem_err_set", 32'(mem_err), 32'd1);
      v.name = "err_frozen2";
      step(v);
      check("err/mem_err_sticky", 32'(mem_err), 32'd1);
      step(rst_v);
      step(idle_vec("err_cleared"));
      check("err/mem_err_clear", 32'(mem_err), 32'd0);

      // ---- reset in the middle of a wait ----
      v = idle_vec("midwait"); v.req = 1; v.rdy = 0; v.stall = 4'b1111; v.flush = 3'b001;
      step(v);
      step(v);
      step(rst_v);
      v = idle_vec("midwait_after_rst"); v.req = 1; v.rdy = 1;
      step(v);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
